// File: rtl/fanout_select_fork_if.sv
// Stream bundle for fanout_select_fork: one producer stream in, NUM_OUT
// consumer streams out sharing a single broadcast payload.
interface fanout_select_fork_if #(
    parameter int NUM_OUT    = 6,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [MASK_WIDTH-1:0] in_mask;
    logic [NUM_OUT-1:0]    out_valid;
    logic [NUM_OUT-1:0]    out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    // Environment side: drives the producer and the consumers' ready lines
    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Fork side: accepts the producer stream and presents the consumer streams
    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fanout_select_fork.sv
// Eager fork with a one-entry holding register. Each captured token is
// offered to every channel whose enable is set and whose selected mask bit
// is 1; each such channel gets the token exactly once, in whatever cycle it
// happens to be ready. Tokens that reach no channel are counted as drops.
module fanout_select_fork #(
    parameter int NUM_OUT    = 6,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = 32,
    parameter int SEL_IDX_W  = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_OUT-1:0]           i_cfg_en,
    input  logic [NUM_OUT*SEL_IDX_W-1:0] i_cfg_sel_idx,
    fanout_select_fork_if.slave          bus,
    output logic [15:0]                  o_drop_count
);
    // The mask is zero-extended to the full index range so that any index
    // at or beyond MASK_WIDTH reads a 0 and leaves the channel untargeted.
    // SEL_IDX_W must be wide enough that EXT_W >= MASK_WIDTH.
    localparam int EXT_W = 1 << SEL_IDX_W;

    logic                  r_hold_valid;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [NUM_OUT-1:0]    r_target;
    logic [NUM_OUT-1:0]    r_done;
    logic [15:0]           r_drop_count;

    logic [EXT_W-1:0]      w_mask_ext;
    logic [NUM_OUT-1:0]    w_target_next;
    logic [NUM_OUT-1:0]    w_out_valid;
    logic [NUM_OUT-1:0]    w_accept;
    logic                  w_complete;
    logic                  w_in_ready;
    logic                  w_capture;
    logic                  w_zero_target_retire;

    assign w_mask_ext = EXT_W'(bus.in_mask);

    // Per-channel target for the incoming token, sampled only at capture
    always_comb begin
        w_target_next = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_target_next[i] = i_cfg_en[i]
                             & w_mask_ext[i_cfg_sel_idx[i*SEL_IDX_W +: SEL_IDX_W]];
        end
    end

    // A channel keeps its valid up until the cycle it accepts; the token
    // completes once every targeted channel has accepted or is accepting now.
    assign w_out_valid = {NUM_OUT{r_hold_valid}} & r_target & ~r_done;
    assign w_accept    = w_out_valid & bus.out_ready;
    assign w_complete  = r_hold_valid & (&(~r_target | r_done | w_accept));

    // Completion frees the register in the same cycle, so a new token can be
    // captured on the retiring edge and full throughput is kept.
    assign w_in_ready = ~rst & (~r_hold_valid | w_complete);
    assign w_capture  = bus.in_valid & w_in_ready;

    assign w_zero_target_retire = w_complete & (r_target == '0);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_hold_data;
    assign o_drop_count  = r_drop_count;

    // Holding register and per-channel delivery bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_target     <= '0;
            r_done       <= '0;
        end else if (w_capture) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= bus.in_data;
            r_target     <= w_target_next;
            r_done       <= '0;
        end else if (w_complete) begin
            r_hold_valid <= 1'b0;
            r_done       <= '0;
        end else begin
            r_done       <= r_done | w_accept;
        end
    end

    // Saturating count of tokens that retired without reaching any channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_zero_target_retire && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end
endmodule
